// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave decoding 16-bit write frames into five PWM control registers.
// Define SPI_READBACK_EN to support read frames shifted out on cipo_o.
module spi_reg_bank #(
  parameter int         NUM_REGS = 5,
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       copi_i,
  input  logic       ncs_i,
  output logic [7:0] en_reg_out_7_0_o,
  output logic [7:0] en_reg_out_15_8_o,
  output logic [7:0] en_reg_pwm_7_0_o,
  output logic [7:0] en_reg_pwm_15_8_o,
  output logic [7:0] pwm_duty_cycle_o,
  output logic       cipo_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t      state_q;
  logic [2:0]  sclk_q, ncs_q;
  logic [1:0]  copi_q;
  logic [4:0]  cnt_q;
  logic [15:0] sr_q;
  logic [7:0]  regs_q [NUM_REGS];
  logic        sclk_rise, ncs_fall, ncs_rise, wr_d;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  // The write lands on the same edge that moves SHIFT into COMMIT, two clk after the pin is first sampled.
  assign wr_d = state_q == SHIFT && ncs_rise && cnt_q == 5'd16 && sr_q[15] && sr_q[14:8] <= MAX_ADDR;
  assign en_reg_out_7_0_o  = regs_q[0];
  assign en_reg_out_15_8_o = regs_q[1];
  assign en_reg_pwm_7_0_o  = regs_q[2];
  assign en_reg_pwm_15_8_o = regs_q[3];
  assign pwm_duty_cycle_o  = regs_q[4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sclk_q  <= 3'b000;
      ncs_q   <= 3'b111;
      copi_q  <= 2'b00;
      cnt_q   <= 5'd0;
      sr_q    <= 16'h0000;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      ncs_q  <= {ncs_q[1:0], ncs_i};
      copi_q <= {copi_q[0], copi_i};
      if (ncs_fall) begin
        state_q <= SHIFT;
        cnt_q   <= 5'd0;
        sr_q    <= 16'h0000;
      end else if (state_q == SHIFT) begin
        if (ncs_rise) state_q <= COMMIT;
        else if (sclk_rise) begin
          sr_q  <= {sr_q[14:0], copi_q[1]};
          cnt_q <= cnt_q == 5'd17 ? cnt_q : cnt_q + 5'd1;
        end
      end else state_q <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) if (wr_d && sr_q[14:8] == 7'(i)) regs_q[i] <= sr_q[7:0];
    end
  end
`ifdef SPI_READBACK_EN
  logic [7:0] out_q, rd_d;
  logic       sclk_fall;
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  always_comb begin
    rd_d = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) if (sr_q[6:0] == 7'(i) && sr_q[6:0] <= MAX_ADDR) rd_d = regs_q[i];
  end
  // Address is complete once 8 bits are in; load then and shift on every later falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= 8'h00;
    else if (ncs_fall) out_q <= 8'h00;
    else if (state_q == SHIFT && sclk_fall) out_q <= cnt_q == 5'd8 ? rd_d : {out_q[6:0], 1'b0};
  end
  assign cipo_o = out_q[7] & ~ncs_q[1];
`else
  assign cipo_o = 1'b0;
`endif
endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

SPI slave front end and register bank that feeds the PWM peripheral. It receives 16-bit write frames on the ui_in-mapped SPI pins (sclk, copi, ncs) and decodes them into the five 8-bit control registers the PWM stage consumes: output enables, PWM enables and duty cycle. It synchronises the asynchronous SPI pins into the system clock domain and commits a frame only when it is well formed.

## Interface
Parameters:
- NUM_REGS, 5, number of implemented registers (addresses 0x00..NUM_REGS-1)
- MAX_ADDR, 7'h04, highest writable address

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sclk  in  1  SPI clock from ui_in[0], asynchronous to clk
- copi  in  1  SPI data in from ui_in[1], asynchronous
- ncs  in  1  SPI chip select from ui_in[2], active-low, asynchronous
- en_reg_out_7_0  out  8  address 0x00
- en_reg_out_15_8  out  8  address 0x01
- en_reg_pwm_7_0  out  8  address 0x02
- en_reg_pwm_15_8  out  8  address 0x03
- pwm_duty_cycle  out  8  address 0x04
- cipo  out  1  SPI data out; present only with SPI_READBACK_EN, otherwise tied 0

Clocking: one clock, clk. Reset: rst_n is asynchronous and active-low.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first. copi is sampled on the rising edge of sclk.
- Frame is 16 bits: bit15 is R/W (1 = write, 0 = read), bits14:8 are the address, bits7:0 are the data.
- sclk, copi and ncs each pass through a 2-FF synchroniser, plus a third FF for edge detection.
- States:
  - IDLE: synced ncs is high.
  - SHIFT: entered on the synced ncs falling edge. Clears the bit counter and shift register. Each synced sclk rising edge shifts in copi and increments the counter.
  - COMMIT: entered on the synced ncs rising edge, lasts one cycle, then returns to IDLE.
- Commit rule: write the register only if all of these hold:
  - bit count is exactly 16;
  - R/W is 1;
  - address is ≤ MAX_ADDR.
- Frames that fail the commit rule are discarded silently. No register changes.
- The bit counter is 5 bits and saturates at 17. Frames longer than 16 bits are discarded.
- A new ncs falling edge while in SHIFT (a glitch) restarts the frame: counter and shift register are cleared.
- sclk edges while synced ncs is high are ignored.
- Reset value of every output is 8'h00; cipo resets to 0. A reset mid-frame aborts the frame and returns to IDLE.

## Timing
- Let N be the clk edge at which the first synchroniser FF captures the ncs rise. The register write happens at edge N+2, and the new value is visible after edge N+2.
- A register holds its value until the next valid write. There is no other path to change it.
- Input constraint: each sclk high and low phase is ≥ 3 clk periods.
- Input constraint: ncs is low for ≥ 3 clk before the first sclk rise, and for ≥ 3 clk after the last sclk fall.
- The block must ignore single-clk glitches on any pin that do not survive the synchroniser.

## Configuration
- SPI_READBACK_EN defined:
  - Read frames (R/W = 0) are supported.
  - On the synced sclk falling edge after bit 8 (address complete), load the addressed register into the shift-out register, or 8'h00 if the address is out of range.
  - cipo presents the MSB, then shifts on each subsequent synced sclk falling edge.
  - cipo is 0 when ncs is high.
  - Read frames never modify registers.
- SPI_READBACK_EN not defined:
  - The cipo port is driven 0.
  - Read frames are discarded.

## Test plan
- Reset: assert rst_n low mid-frame -> all five outputs read 8'h00, cipo is 0, and the next valid frame commits normally.
- Write: send 0x8055, then 0x84C0 -> en_reg_out_7_0 = 0x55 and pwm_duty_cycle = 0xC0, each updating 2 clk after the synchronised ncs rise; other registers unchanged.
- Malformed frames: 15-bit frame 0x8123>>1, 17-bit frame, and write to address 0x05 (0x85AA) -> no register changes.
- Direction: read frame 0x0233 without SPI_READBACK_EN -> en_reg_pwm_7_0 unchanged.
- Readback: with SPI_READBACK_EN, after writing 0x8203, read frame 0x0200 -> cipo shifts out 0x03 MSB-first during bits 7:0.
- Glitch: a 1-clk ncs high pulse inside a frame -> frame restarts; only the subsequent complete 16 bits commit.
